// File: rtl/mult_pkg.sv
// Shared constants for the Booth multiplier: FSM encoding, Booth step decode
// and the last iteration index.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] BOOTH_NOP = 2'd0;
  localparam logic [1:0] BOOTH_ADD = 2'd1;
  localparam logic [1:0] BOOTH_SUB = 2'd2;

  localparam logic [4:0] LAST_ITER = 5'd31;

  // Radix-2 Booth recoding of the pair {Q[0], q_1}.
  function automatic logic [1:0] booth_decode(input logic q0, input logic q_1);
    unique case ({q0, q_1})
      2'b01:   booth_decode = BOOTH_ADD;
      2'b10:   booth_decode = BOOTH_SUB;
      default: booth_decode = BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with group
// generate/propagate chained between groups.
module cla_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o,
  output logic        ovf_o
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic [32:0] c;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;

  // Carry network: group carries come from group G/P, bit carries within a group.
  always_comb begin
    gen   = a_i & b_i;
    prop  = a_i ^ b_i;
    c     = '0;
    c[0]  = cin_i;
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < 8; j++) begin
      grp_g[j] = gen[4*j+3]
               | (prop[4*j+3] & gen[4*j+2])
               | (prop[4*j+3] & prop[4*j+2] & gen[4*j+1])
               | (prop[4*j+3] & prop[4*j+2] & prop[4*j+1] & gen[4*j]);
      grp_p[j] = prop[4*j+3] & prop[4*j+2] & prop[4*j+1] & prop[4*j];
      for (int k = 0; k < 3; k++) begin
        c[4*j+k+1] = gen[4*j+k] | (prop[4*j+k] & c[4*j+k]);
      end
      c[4*j+4] = grp_g[j] | (grp_p[j] & c[4*j]);
    end
  end

  // Sum and flags.
  always_comb begin
    sum_o  = prop ^ c[31:0];
    cout_o = c[32];
    ovf_o  = c[32] ^ c[31];
  end

endmodule

// File: rtl/mult_booth_32.sv
// Multicycle signed 32x32 radix-2 Booth multiplier built around cla_32.
// Returns product[31:0], an overflow flag (product not representable in
// signed 32 bits) and a one-cycle ready pulse 33 cycles after start.
// Optional macro MULT_ZERO_SKIP_EN: a zero operand finishes in one cycle.
module mult_booth_32
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   a_q, a_d;    // 33-bit accumulator so M = 0x80000000 stays exact
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [1:0]       booth;
  logic             sub;
  logic [WIDTH-1:0] cla_b;
  logic [WIDTH-1:0] cla_sum;
  logic             cla_cout;
  logic             mx_top;
  logic [WIDTH:0]   a_sel;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q1_next;
  logic [WIDTH:0]   prod_hi;
  logic             exc_next;

  cla_32 u_cla (
    .a_i    (a_q[WIDTH-1:0]),
    .b_i    (cla_b),
    .cin_i  (sub),
    .sum_o  (cla_sum),
    .cout_o (cla_cout),
    .ovf_o  ()
  );

  // One Booth step: add/sub M into A, then arithmetic shift of {A, Q, q_1}.
  always_comb begin
    booth   = booth_decode(q_q[0], q1_q);
    sub     = (booth == BOOTH_SUB);
    cla_b   = sub ? ~m_q : m_q;
    mx_top  = sub ? ~m_q[WIDTH-1] : m_q[WIDTH-1];
    a_sel   = (booth == BOOTH_NOP) ? a_q : {a_q[WIDTH] ^ mx_top ^ cla_cout, cla_sum};
    {a_next, q_next, q1_next} = {a_sel[WIDTH], a_sel, q_q};
    // Product fits in signed 32 bits iff bits [63:31] are all equal.
    prod_hi  = {a_next[WIDTH-1:0], q_next[WIDTH-1]};
    exc_next = ~((prod_hi == '0) || (prod_hi == '1));
  end

  // Next-state: start has priority in every state and restarts the datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    q_d      = q_q;
    q1_d     = q1_q;
    m_d      = m_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (ctrl_MULT) begin
      m_d     = data_operandA;
      a_d     = '0;
      q_d     = data_operandB;
      q1_d    = 1'b0;
      cnt_d   = '0;
      state_d = ST_RUN;
`ifdef MULT_ZERO_SKIP_EN
      if ((data_operandA == '0) || (data_operandB == '0)) begin
        state_d  = ST_DONE;
        result_d = '0;
        exc_d    = 1'b0;
        rdy_d    = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
          a_d   = a_next;
          q_d   = q_next;
          q1_d  = q1_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d  = ST_DONE;
            result_d = q_next;
            exc_d    = exc_next;
            rdy_d    = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_mult_booth_32.sv
// Self-checking bench for mult_booth_32: directed cases plus random operands
// against a plain signed-multiply reference.
module tb_mult_booth_32;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_cmp  = 0;
  int n_fail = 0;

  mult_booth_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact 64-bit signed product.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic logic ref_exc(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Called at a negedge; drives a start across the next rising edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Cycles (negedges) after the start edge until RDY; -1 if it never came.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input int lat);
    check({tag, "_lat"}, lat, ref_lat(a, b));
    check({tag, "_res"}, data_result, ref_result(a, b));
    check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, ref_exc(a, b)});
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat;
    launch(a, b);
    wait_rdy(lat);
    check_done(tag, a, b, lat);
    @(negedge clock);
    check({tag, "_rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_hold"}, data_result, ref_result(a, b));
  endtask

  initial begin
    int lat;
    int nrdy;
    logic [31:0] ra;
    logic [31:0] rb;

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset_res", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("m3x5", 32'd3, 32'd5);
    run_op("m_n7x6", 32'hFFFF_FFF9, 32'd6);
    run_op("m_n7xn6", 32'hFFFF_FFF9, 32'hFFFF_FFFA);
    run_op("min_x1", 32'h8000_0000, 32'd1);
    run_op("min_xn1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("min_xmin", 32'h8000_0000, 32'h8000_0000);
    run_op("p16xp16", 32'h0001_0000, 32'h0001_0000);
    run_op("max_x2", 32'h7FFF_FFFF, 32'd2);
    run_op("zero_a", 32'd0, 32'd123);
    run_op("zero_b", 32'hDEAD_BEEF, 32'd0);

    // Restart during RUN: aborted op must not produce RDY.
    ra = $urandom | 32'd1;
    rb = $urandom | 32'd1;
    launch(ra, rb);
    nrdy = 0;
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) nrdy++;
    end
    @(negedge clock);
    launch(32'd2, 32'd9);
    wait_rdy(lat);
    check("restart_no_rdy", nrdy, 32'd0);
    check_done("restart", 32'd2, 32'd9, lat);

    // Start in the DONE cycle: RDY already shown, new op begins on that edge.
    launch(32'd11, 32'hFFFF_FFFD);
    wait_rdy(lat);
    check_done("b2b_first", 32'd11, 32'hFFFF_FFFD, lat);
    launch(32'd1000, 32'd77);
    wait_rdy(lat);
    check_done("b2b_second", 32'd1000, 32'd77, lat);
    @(negedge clock);

    // Asynchronous reset mid-operation clears outputs immediately.
    launch(32'd12345, 32'd678);
    repeat (20) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_res", data_result, 32'd0);
    check("async_rst_exc", {31'd0, data_exception}, 32'd0);
    check("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    nrdy = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) nrdy++;
    end
    check("after_rst_no_rdy", nrdy, 32'd0);
    run_op("m4x4", 32'd4, 32'd4);

    // Random operands: full range, small signed, occasional zero.
    for (int i = 0; i < 24; i++) begin
      unique case (i % 4)
        0: begin ra = $urandom;                          rb = $urandom; end
        1: begin ra = $urandom_range(2000, 0) - 32'd1000; rb = $urandom_range(2000, 0) - 32'd1000; end
        2: begin ra = $urandom;                          rb = $urandom_range(0, 0); end
        default: begin ra = $urandom_range(65535, 0);    rb = $urandom; end
      endcase
      run_op($sformatf("rnd%0d", i), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
